// File: rtl/writeback_regfile.sv
// Write-back stage and 2**ADDR_W x DATA_W register file: destination/data selection,
// edge-committed writes, and three combinational read ports.
module writeback_regfile #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned RA_INDEX = 31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [1:0]        RegDst,
   input  logic [1:0]        MemtoReg,
   input  logic [ADDR_W-1:0] Rs,
   input  logic [ADDR_W-1:0] Rt,
   input  logic [ADDR_W-1:0] Rd,
   input  logic [DATA_W-1:0] ALUOut,
   input  logic [DATA_W-1:0] MemReadData,
   input  logic [DATA_W-1:0] PCPlus4,
   input  logic [ADDR_W-1:0] DbgAddr,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic [ADDR_W-1:0] WriteAddr,
   output logic [DATA_W-1:0] WriteData,
   output logic [DATA_W-1:0] DbgData
);

   localparam int unsigned NumRegs = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] RaAddr = ADDR_W'(RA_INDEX);

   logic [DATA_W-1:0] regFile [NumRegs];

   always_comb begin
      WriteAddr = Rd;
      case (RegDst)
         2'b01:   WriteAddr = Rt;
         2'b10:   WriteAddr = RaAddr;
         default: WriteAddr = Rd;
      endcase
   end

   always_comb begin
      WriteData = ALUOut;
      case (MemtoReg)
         2'b01:   WriteData = MemReadData;
         2'b10:   WriteData = PCPlus4;
         default: WriteData = ALUOut;
      endcase
   end

   // Entry 0 is never targeted, so it stays at its reset value of zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regFile <= '{default: '0};
      end else if (RegWrite && (WriteAddr != '0)) begin
         regFile[WriteAddr] <= WriteData;
      end
   end

   // No write bypass: a same-cycle read of the destination returns the old value.
   assign ReadData1 = (Rs == '0)      ? '0 : regFile[Rs];
   assign ReadData2 = (Rt == '0)      ? '0 : regFile[Rt];
   assign DbgData   = (DbgAddr == '0) ? '0 : regFile[DbgAddr];

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed and randomized bench for writeback_regfile: an array scoreboard checked every
// cycle, plus literal expectations from the register-file test list.
module tb_writeback_regfile;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        RegWrite = 1'b0;
   logic [1:0]  RegDst = 2'b00;
   logic [1:0]  MemtoReg = 2'b00;
   logic [4:0]  Rs = '0, Rt = '0, Rd = '0, DbgAddr = '0;
   logic [31:0] ALUOut = '0, MemReadData = '0, PCPlus4 = '0;
   logic [31:0] ReadData1, ReadData2, WriteData, DbgData;
   logic [4:0]  WriteAddr;

   int tests = 0;
   int fails = 0;
   bit checkEn = 1'b0;
   logic [31:0] model [32];

   writeback_regfile #(.DATA_W(32), .ADDR_W(5), .RA_INDEX(31)) dut (
      .clk(clk), .reset(reset), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .Rs(Rs), .Rt(Rt), .Rd(Rd), .ALUOut(ALUOut), .MemReadData(MemReadData),
      .PCPlus4(PCPlus4), .DbgAddr(DbgAddr), .ReadData1(ReadData1), .ReadData2(ReadData2),
      .WriteAddr(WriteAddr), .WriteData(WriteData), .DbgData(DbgData)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] expAddr(logic [1:0] dst, logic [4:0] rt, logic [4:0] rd);
      if (dst == 2'b01) return rt;
      if (dst == 2'b10) return 5'd31;
      return rd;
   endfunction

   function automatic logic [31:0] expData(logic [1:0] m, logic [31:0] alu, logic [31:0] mem,
                                           logic [31:0] pc);
      if (m == 2'b01) return mem;
      if (m == 2'b10) return pc;
      return alu;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial foreach (model[i]) model[i] = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         foreach (model[i]) model[i] <= '0;
      end else if (RegWrite && expAddr(RegDst, Rt, Rd) != 5'd0) begin
         model[expAddr(RegDst, Rt, Rd)] <= expData(MemtoReg, ALUOut, MemReadData, PCPlus4);
      end
   end

   always @(negedge clk) begin
      if (checkEn) begin
         check("sb_rd1", ReadData1, model[Rs]);
         check("sb_rd2", ReadData2, model[Rt]);
         check("sb_dbg", DbgData, model[DbgAddr]);
         check("sb_waddr", {27'd0, WriteAddr}, {27'd0, expAddr(RegDst, Rt, Rd)});
         check("sb_wdata", WriteData, expData(MemtoReg, ALUOut, MemReadData, PCPlus4));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2 reset = 1'b1;
      tick();
      reset = 1'b0;
      checkEn = 1'b1;
      #1;
      check("reset_rd1", ReadData1, 32'h0);
      check("reset_dbg", DbgData, 32'h0);

      // 1: populate $5 and $31, then async reset clears them before the next edge
      RegWrite = 1'b1; RegDst = 2'b00; Rd = 5'd5; MemtoReg = 2'b00; ALUOut = 32'hAAAA_5555;
      tick();
      RegDst = 2'b10; MemtoReg = 2'b10; PCPlus4 = 32'h0040_0100;
      tick();
      Rs = 5'd5; Rt = 5'd31; DbgAddr = 5'd31; RegDst = 2'b00; Rd = 5'd7;
      #1;
      check("pre_reset_r5", ReadData1, 32'hAAAA_5555);
      check("pre_reset_r31", ReadData2, 32'h0040_0100);
      reset = 1'b1;
      #1;
      check("async_rd1", ReadData1, 32'h0);
      check("async_rd2", ReadData2, 32'h0);
      check("async_dbg", DbgData, 32'h0);
      tick();
      reset = 1'b0;
      Rs = 5'd7; RegWrite = 1'b0;
      #1;
      check("reset_blocks_write", ReadData1, 32'h0);

      // 2: R-type write to $8, old value visible before the edge
      RegWrite = 1'b1; RegDst = 2'b00; Rd = 5'd8; MemtoReg = 2'b00; ALUOut = 32'h1234_5678;
      Rs = 5'd8; DbgAddr = 5'd8;
      #1;
      check("rdw_old", ReadData1, 32'h0);
      tick();
      check("r8_written", DbgData, 32'h1234_5678);

      // 3: load into Rt, then code 11 falls back to Rd
      RegDst = 2'b01; Rt = 5'd9; MemtoReg = 2'b01; MemReadData = 32'hDEAD_BEEF;
      #1;
      check("waddr_rt", {27'd0, WriteAddr}, 32'd9);
      check("wdata_mem", WriteData, 32'hDEAD_BEEF);
      tick();
      DbgAddr = 5'd9; RegDst = 2'b11; Rd = 5'd10;
      #1;
      check("r9_written", DbgData, 32'hDEAD_BEEF);
      check("waddr_code11", {27'd0, WriteAddr}, 32'd10);
      tick();
      DbgAddr = 5'd10;
      #1;
      check("r10_written", DbgData, 32'hDEAD_BEEF);

      // 4: jal link write, then MemtoReg=11 selects ALUOut
      RegDst = 2'b10; MemtoReg = 2'b10; PCPlus4 = 32'h0040_0008;
      #1;
      check("waddr_ra", {27'd0, WriteAddr}, 32'd31);
      tick();
      DbgAddr = 5'd31; RegWrite = 1'b0; MemtoReg = 2'b11; ALUOut = 32'hCAFE_F00D;
      #1;
      check("r31_link", DbgData, 32'h0040_0008);
      check("wdata_code11", WriteData, 32'hCAFE_F00D);

      // 5: write to $0 is discarded
      RegWrite = 1'b1; RegDst = 2'b00; Rd = 5'd0; MemtoReg = 2'b00; ALUOut = 32'hFFFF_FFFF;
      tick();
      Rs = 5'd0; DbgAddr = 5'd0; RegWrite = 1'b0;
      #1;
      check("r0_zero_rd1", ReadData1, 32'h0);
      check("r0_zero_dbg", DbgData, 32'h0);

      // 6: ten edges with RegWrite=0 and muxes exercised
      for (int i = 0; i < 10; i++) begin
         RegDst = 2'(i); MemtoReg = 2'(i + 1); Rd = 5'd8; Rt = 5'd9;
         ALUOut = $urandom; MemReadData = $urandom; PCPlus4 = $urandom;
         tick();
      end
      Rs = 5'd8; Rt = 5'd10; DbgAddr = 5'd31;
      #1;
      check("hold_r8", ReadData1, 32'h1234_5678);
      check("hold_r10", ReadData2, 32'hDEAD_BEEF);
      check("hold_r31", DbgData, 32'h0040_0008);

      // random sweep; the scoreboard checks every cycle
      for (int i = 0; i < 400; i++) begin
         RegWrite = ($urandom_range(0, 3) != 0);
         RegDst = 2'($urandom_range(0, 3));
         MemtoReg = 2'($urandom_range(0, 3));
         Rs = 5'($urandom); Rt = 5'($urandom); Rd = 5'($urandom); DbgAddr = 5'($urandom);
         ALUOut = $urandom; MemReadData = $urandom; PCPlus4 = $urandom;
         tick();
      end
      RegWrite = 1'b0;
      for (int i = 0; i < 32; i++) begin
         DbgAddr = 5'(i);
         #1;
         check("final_sweep", DbgData, model[i]);
      end
      checkEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
